// File: rtl/enc32_5_rr.sv
// enc32_5_rr -- registered round-robin 32-to-5 encoder (arbiter).
//
// Picks one pending requester out of 32 request lines and presents its
// 5-bit index (plus a one-hot copy) under a valid/ready handshake. A
// rotating priority pointer makes the choice fair: the search for the next
// winner starts just past the previous winner. Outputs come straight from
// flops; there is no combinational path from req to any output.
//
// Ports:
//   clk           in   1   system clock, rising edge
//   reset         in   1   asynchronous, active-high reset
//   req           in   32  request vector, bit i = requester i pending
//   grant_ready   in   1   consumer accepts the current grant this cycle
//   grant_valid   out  1   grant_idx / grant_onehot hold a valid grant
//   grant_idx     out  5   encoded index of the granted requester
//   grant_onehot  out  32  one-hot of grant_idx, zero when grant_valid=0
//
// Build option:
//   ENC32_FIXED_PRIO_EN  when defined, the pointer is tied to 0 and the
//                        block becomes a fixed-priority encoder (lowest
//                        set index wins); handshake rules are unchanged.

module enc32_5_rr #(
  parameter int unsigned N = 32,
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         grant_ready,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_onehot
);

  logic         grant_valid_q,  grant_valid_d;
  logic [W-1:0] grant_idx_q,    grant_idx_d;
  logic [N-1:0] grant_onehot_q, grant_onehot_d;
  logic [W-1:0] ptr;

  logic         slot_free;
  logic         found;
  logic [W-1:0] win_idx;
  logic [W-1:0] cand;

  // The output slot can take a new grant when it is empty or when the
  // current grant is being accepted on this edge (no bubble).
  assign slot_free = !grant_valid_q || grant_ready;

  // Circular scan starting at ptr. The 5-bit add wraps naturally, so the
  // order is ptr, ptr+1, ..., 31, 0, ..., ptr-1.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr + W'(i);
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    grant_valid_d  = grant_valid_q;
    grant_idx_d    = grant_idx_q;
    grant_onehot_d = grant_onehot_q;
    if (slot_free) begin
      if (found) begin
        grant_valid_d  = 1'b1;
        grant_idx_d    = win_idx;
        grant_onehot_d = N'(1) << win_idx;
      end else begin
        // Nothing pending: drop valid, keep the last index for reference.
        grant_valid_d  = 1'b0;
        grant_onehot_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_valid_q  <= 1'b0;
      grant_idx_q    <= '0;
      grant_onehot_q <= '0;
    end else begin
      grant_valid_q  <= grant_valid_d;
      grant_idx_q    <= grant_idx_d;
      grant_onehot_q <= grant_onehot_d;
    end
  end

`ifdef ENC32_FIXED_PRIO_EN
  // Fixed priority: search always starts at requester 0.
  assign ptr = '0;
`else
  logic [W-1:0] ptr_q, ptr_d;

  // Pointer moves one past the winner only when a new grant is issued;
  // the 5-bit add wraps 31 back to 0.
  always_comb begin
    ptr_d = ptr_q;
    if (slot_free && found) begin
      ptr_d = win_idx + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`endif

  assign grant_valid  = grant_valid_q;
  assign grant_idx    = grant_idx_q;
  assign grant_onehot = grant_onehot_q;

endmodule
